alu_share_arbiter: RTL and testbench

- Shares one ALU datapath between two requesters, port 0 and port 1. Example pairing: the EXU operand path on one port and the address/branch-compare path on the other.
- Performs round-robin arbitration with valid/ready handshakes.
- Pipeline: registered operand stage, then registered result stage. One transaction is in flight at a time.
- The result is returned only to the requester that issued it.

---
 rtl/alu_share_pkg.sv | 33 +++
 rtl/alu_share_arbiter_if.sv | 44 ++++
 rtl/alu_core.sv | 42 ++++
 rtl/alu_share_arbiter.sv | 107 ++++++++++
 tb/tb_alu_share_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_pkg.sv
// Shared opcodes, FSM state type and opcode legality helper for the
// two-port shared ALU arbiter.
package alu_share_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD   = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB   = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SLL   = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SLT   = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SLTU  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_XOR   = 4'b1000;
    localparam logic [OP_W-1:0] ALU_OR    = 4'b1100;
    localparam logic [OP_W-1:0] ALU_AND   = 4'b1110;
    localparam logic [OP_W-1:0] ALU_SRL   = 4'b1010;
    localparam logic [OP_W-1:0] ALU_SRA   = 4'b1011;
    localparam logic [OP_W-1:0] ALU_PASSB = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
            ALU_OR, ALU_AND, ALU_SRL, ALU_SRA, ALU_PASSB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two requesters and the shared ALU.
interface alu_share_arbiter_if
    import alu_share_pkg::*;
#(
    parameter int unsigned BITWIDTH = 32
);
    logic                req0_valid;
    logic                req0_ready;
    logic [OP_W-1:0]     req0_op;
    logic [BITWIDTH-1:0] req0_a;
    logic [BITWIDTH-1:0] req0_b;

    logic                req1_valid;
    logic                req1_ready;
    logic [OP_W-1:0]     req1_op;
    logic [BITWIDTH-1:0] req1_a;
    logic [BITWIDTH-1:0] req1_b;

    logic                rsp0_valid;
    logic                rsp0_ready;
    logic                rsp1_valid;
    logic                rsp1_ready;
    logic [BITWIDTH-1:0] rsp_result;
    logic                rsp_zero;
    logic                rsp_illegal;
    logic                busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_illegal, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_illegal, busy
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU: op/a/b to result, zero flag and illegal flag.
module alu_core
    import alu_share_pkg::*;
#(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned SHAMT_W  = $clog2(BITWIDTH)
) (
    input  logic [OP_W-1:0]     op,
    input  logic [BITWIDTH-1:0] a,
    input  logic [BITWIDTH-1:0] b,
    output logic [BITWIDTH-1:0] result_c,
    output logic                zero_c,
    output logic                illegal_c
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

    // Illegal codes fall through to a zero result.
    always_comb begin
        result_c = '0;
        case (op)
            ALU_ADD:   result_c = a + b;
            ALU_SUB:   result_c = a - b;
            ALU_SLL:   result_c = a << shamt;
            ALU_SLT:   result_c = BITWIDTH'($signed(a) < $signed(b));
            ALU_SLTU:  result_c = BITWIDTH'(a < b);
            ALU_XOR:   result_c = a ^ b;
            ALU_OR:    result_c = a | b;
            ALU_AND:   result_c = a & b;
            ALU_SRL:   result_c = a >> shamt;
            ALU_SRA:   result_c = BITWIDTH'($signed(a) >>> shamt);
            ALU_PASSB: result_c = b;
            default:   result_c = '0;
        endcase
    end

    assign zero_c    = (result_c == '0);
    assign illegal_c = !is_legal_op(op);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters;
// one transaction in flight, result returned only to the issuing port.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned SHAMT_W  = $clog2(BITWIDTH)
) (
    input logic                clk,
    input logic                rst,
    alu_share_arbiter_if.slave bus
);

    state_e              state_q;
    state_e              state_d;
    logic                last_grant_q;
    logic                owner_q;
    logic [OP_W-1:0]     op_q;
    logic [BITWIDTH-1:0] a_q;
    logic [BITWIDTH-1:0] b_q;
    logic [BITWIDTH-1:0] result_q;
    logic                zero_q;
    logic                illegal_q;

    logic                owner_ready_c;
    logic                rsp_fire_c;
    logic                open_c;
    logic                grant0_c;
    logic                grant1_c;
    logic                req_fire_c;

    logic [BITWIDTH-1:0] alu_result_c;
    logic                alu_zero_c;
    logic                alu_illegal_c;

    // Accept window, grant selection and next state.
    always_comb begin
        owner_ready_c = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        rsp_fire_c    = (state_q == RESP) && owner_ready_c;
        open_c        = (state_q == IDLE) || rsp_fire_c;
        grant0_c      = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1_c      = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        req_fire_c    = open_c && (grant0_c || grant1_c);
        state_d       = state_q;
        case (state_q)
            IDLE:    if (req_fire_c) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_fire_c) state_d = req_fire_c ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture on fire; result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            if (req_fire_c) begin
                last_grant_q <= grant1_c;
                owner_q      <= grant1_c;
                op_q         <= grant1_c ? bus.req1_op : bus.req0_op;
                a_q          <= grant1_c ? bus.req1_a  : bus.req0_a;
                b_q          <= grant1_c ? bus.req1_b  : bus.req0_b;
            end
            if (state_q == EXEC) begin
                result_q  <= alu_result_c;
                zero_q    <= alu_zero_c;
                illegal_q <= alu_illegal_c;
            end
        end
    end

    alu_core #(
        .BITWIDTH (BITWIDTH),
        .SHAMT_W  (SHAMT_W)
    ) u_alu_core (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .result_c  (alu_result_c),
        .zero_c    (alu_zero_c),
        .illegal_c (alu_illegal_c)
    );

    // req_ready is combinational on rsp_ready through the accept window.
    assign bus.req0_ready  = open_c && grant0_c;
    assign bus.req1_ready  = open_c && grant1_c;
    assign bus.rsp0_valid  = (state_q == RESP) && !owner_q;
    assign bus.rsp1_valid  = (state_q == RESP) &&  owner_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_zero    = zero_q;
    assign bus.rsp_illegal = illegal_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_share_arbiter_if #(.BITWIDTH(32)) bus ();

    alu_share_arbiter #(.BITWIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int p, input logic v, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Issue one op on port p with both rsp_ready high, check full timeline.
    task automatic run_op(input int p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er,
                          input logic ez, input logic ei, input string tag);
        int   n;
        logic rdy;
        drive_req(p, 1'b1, op, a, b);
        #1;
        rdy = (p == 0) ? bus.req0_ready : bus.req1_ready;
        n   = 0;
        while (!rdy && n < 10) begin
            step();
            rdy = (p == 0) ? bus.req0_ready : bus.req1_ready;
            n++;
        end
        chk($sformatf("%s_ready", tag), 32'(rdy), 32'd1);
        step();
        drive_req(p, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk($sformatf("%s_exec_rspv", tag), 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        step();
        chk($sformatf("%s_rspv", tag), 32'({bus.rsp1_valid, bus.rsp0_valid}),
            (p == 0) ? 32'd1 : 32'd2);
        chk($sformatf("%s_result", tag), bus.rsp_result, er);
        chk($sformatf("%s_zero", tag), 32'(bus.rsp_zero), 32'(ez));
        chk($sformatf("%s_illegal", tag), 32'(bus.rsp_illegal), 32'(ei));
        step();
        chk($sformatf("%s_idle", tag), 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [31:0] held;

    initial begin
        n_checks = 0;
        n_errors = 0;
        drive_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        rst = 1'b1;
        do_reset();

        // Reset state
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rspv", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        chk("rst_result", bus.rsp_result, 32'd0);
        chk("rst_flags", 32'({bus.rsp_zero, bus.rsp_illegal}), 32'd0);
        chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);

        // Basic op and arithmetic corners
        run_op(0, ALU_ADD,  32'd5,        32'd7,  32'd12,       1'b0, 1'b0, "add");
        run_op(1, ALU_SUB,  32'd9,        32'd9,  32'd0,        1'b1, 1'b0, "sub_zero");
        run_op(0, ALU_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, "sra");
        run_op(1, ALU_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, "srl");
        run_op(0, ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1,        1'b0, 1'b0, "slt");
        run_op(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0,        1'b1, 1'b0, "sltu");
        run_op(0, ALU_ADD,  32'hFFFF_FFFF, 32'd1, 32'd0,        1'b1, 1'b0, "add_wrap");
        run_op(1, ALU_SLL,  32'd1,        32'h3F, 32'h8000_0000, 1'b0, 1'b0, "sll_shamt");
        run_op(0, ALU_PASSB, 32'h1234,    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, "passb");
        run_op(1, ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, "and");
        run_op(0, ALU_OR,   32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, "or");

        // Illegal opcode, then a legal op clears the flag
        run_op(1, 4'b0011, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, "illegal");
        run_op(1, ALU_XOR, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, "legal_after");

        // Contention: both valid, grants alternate starting at port 0
        do_reset();
        drive_req(0, 1'b1, ALU_ADD, 32'd10,  32'd20);
        drive_req(1, 1'b1, ALU_SUB, 32'd100, 32'd1);
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c % 2 == 0) begin
                chk($sformatf("cont_ready_c%0d", c), 32'({bus.req1_ready, bus.req0_ready}),
                    ((c / 2) % 2 == 0) ? 32'd1 : 32'd2);
                if (c >= 2) begin
                    chk($sformatf("cont_rspv_c%0d", c), 32'({bus.rsp1_valid, bus.rsp0_valid}),
                        (((c / 2) - 1) % 2 == 0) ? 32'd1 : 32'd2);
                    chk($sformatf("cont_res_c%0d", c), bus.rsp_result,
                        (((c / 2) - 1) % 2 == 0) ? 32'd30 : 32'd99);
                end
            end else begin
                chk($sformatf("cont_ready_c%0d", c), 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
                chk($sformatf("cont_rspv_c%0d", c), 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
            end
            step();
        end
        drive_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("cont_last_rspv", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd2);
        chk("cont_last_res", bus.rsp_result, 32'd99);
        step();
        chk("cont_idle", 32'(bus.busy), 32'd0);

        // Backpressure on port 1 while port 0 waits
        bus.rsp1_ready = 1'b0;
        drive_req(1, 1'b1, ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
        #1;
        chk("bp_req1_ready", 32'(bus.req1_ready), 32'd1);
        step();
        drive_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_req(0, 1'b1, ALU_ADD, 32'd1, 32'd2);
        #1;
        chk("bp_exec_req0_ready", 32'(bus.req0_ready), 32'd0);
        step();
        held = bus.rsp_result;
        chk("bp_result", held, 32'hF00F_F00F);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold_rspv_%0d", i), 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd2);
            chk($sformatf("bp_hold_res_%0d", i), bus.rsp_result, 32'hF00F_F00F);
            chk($sformatf("bp_hold_req0_ready_%0d", i), 32'(bus.req0_ready), 32'd0);
            step();
        end
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_release_req0_ready", 32'(bus.req0_ready), 32'd1);
        step();
        drive_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("bp_after_rspv", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        chk("bp_after_busy", 32'(bus.busy), 32'd1);
        step();
        chk("bp_rsp0_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd1);
        chk("bp_rsp0_result", bus.rsp_result, 32'd3);
        step();

        // Reset while in EXEC: no response, port 0 wins the next tie
        drive_req(0, 1'b1, ALU_ADD, 32'd40, 32'd2);
        step();
        drive_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rexec_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rexec_rspv_%0d", i), 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
            step();
        end
        drive_req(0, 1'b1, ALU_SUB, 32'd50, 32'd8);
        drive_req(1, 1'b1, ALU_ADD, 32'd1,  32'd1);
        #1;
        chk("rexec_tie_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
        step();
        drive_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
        step();
        chk("rexec_tie_rspv", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd1);
        chk("rexec_tie_res", bus.rsp_result, 32'd42);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
